// File: rtl/iter_divider_pkg.sv
// -----------------------------------------------------------------------------
// iter_divider_pkg
//   Shared definitions for the iterative divider: div_op bit positions, the
//   controller state encoding and a helper that qualifies the op field.
// -----------------------------------------------------------------------------
package iter_divider_pkg;

  // Bit positions inside div_op
  localparam int DIV_OP_SIGNED   = 0;  // DIV  (signed)
  localparam int DIV_OP_UNSIGNED = 1;  // DIVU (unsigned)

  // Controller states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  // Exactly one of the two op bits must be set; 00 and 11 are no-ops.
  function automatic logic op_is_legal(input logic [1:0] op);
    return op[DIV_OP_SIGNED] ^ op[DIV_OP_UNSIGNED];
  endfunction

endpackage

// File: rtl/iter_divider_div_step.sv
// -----------------------------------------------------------------------------
// iter_divider_div_step
//   One combinational radix-2 restoring step on WIDTH+1 bits.
//   Ports:
//     rem_i     partial remainder (always < divisor_i when divisor_i != 0)
//     quo_i     partial quotient / remaining dividend bits
//     divisor_i divisor magnitude
//     rem_o     remainder after shift and conditional subtract
//     quo_o     quotient after shift, new bit in the LSB
// -----------------------------------------------------------------------------
module iter_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] trial_s;
  logic           fits_s;

  // Shift {rem,quo} left by one, trial-subtract the divisor, keep or restore.
  // Because rem_i < divisor, the shifted remainder is < 2*divisor, so the
  // MSB of the WIDTH+1 bit difference is a correct borrow indicator.
  always_comb begin
    rem_sh_s = {rem_i, quo_i[WIDTH-1]};
    trial_s  = rem_sh_s - {1'b0, divisor_i};
    fits_s   = ~trial_s[WIDTH];
    if (fits_s) begin
      rem_o = trial_s[WIDTH-1:0];
    end else begin
      rem_o = rem_sh_s[WIDTH-1:0];
    end
    quo_o = {quo_i[WIDTH-2:0], fits_s};
  end

endmodule

// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
//   Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
//   Signed operands are converted to magnitudes, divided, then the result
//   signs are applied in a single FIX cycle.
//   Ports:
//     clk, resetn          clock, asynchronous active-low reset
//     in_valid/in_ready    operand handshake (in_ready = IDLE && !flush)
//     div_op[1:0]          [0] signed, [1] unsigned; 00/11 never accepted
//     dividend, divisor    operands
//     flush                cancel any in-flight or pending operation
//     out_valid/out_ready  result handshake
//     quotient, remainder  results (LO / HI), held until next result
//     busy                 controller not in IDLE
// -----------------------------------------------------------------------------
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV0_FAST = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic             accept_s;
  logic             is_signed_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic             div0_s;
  logic             fast_div0_s;
  logic [WIDTH-1:0] a_abs_s;
  logic [WIDTH-1:0] b_abs_s;
  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_quo_s;

  iter_divider_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (step_rem_s),
    .quo_o    (step_quo_s)
  );

  assign in_ready  = (state_q == ST_IDLE) && !flush;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

  // Operand qualification and magnitude conversion at the accept point.
  always_comb begin
    accept_s    = in_valid && in_ready && op_is_legal(div_op);
    is_signed_s = div_op[DIV_OP_SIGNED];
    a_neg_s     = is_signed_s & dividend[WIDTH-1];
    b_neg_s     = is_signed_s & divisor[WIDTH-1];
    div0_s      = ~|divisor;
    fast_div0_s = (DIV0_FAST != 32'sd0) && div0_s;
    if (a_neg_s) begin
      a_abs_s = -dividend;
    end else begin
      a_abs_s = dividend;
    end
    if (b_neg_s) begin
      b_abs_s = -divisor;
    end else begin
      b_abs_s = divisor;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_d = fast_div0_s ? ST_FIX : ST_CALC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_CALC;
          end
        end
        ST_FIX: begin
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath next values: operand latch, iteration, sign fix-up.
  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    div0_d      = div0_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    if (flush) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            cnt_d     = {CNT_W{1'b0}};
            dvs_d     = b_abs_s;
            neg_quo_d = a_neg_s ^ b_neg_s;
            neg_rem_d = a_neg_s;
            div0_d    = div0_s;
            if (fast_div0_s) begin
              // Skip the iteration: the remainder magnitude is |a| directly.
              rem_d = a_abs_s;
              quo_d = {WIDTH{1'b1}};
            end else begin
              rem_d = {WIDTH{1'b0}};
              quo_d = a_abs_s;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_CALC: begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_FIX: begin
          // For divide-by-zero the remainder path still yields the original
          // dividend (|a| re-negated), but the quotient sign must not be
          // applied to the all-ones result.
          if (div0_q) begin
            quotient_d = {WIDTH{1'b1}};
          end else if (neg_quo_q) begin
            quotient_d = -quo_q;
          end else begin
            quotient_d = quo_q;
          end
          if (neg_rem_q) begin
            remainder_d = -rem_q;
          end else begin
            remainder_d = rem_q;
          end
        end
        ST_DONE: begin
          cnt_d = {CNT_W{1'b0}};
        end
        default: begin
          cnt_d = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= {CNT_W{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      dvs_q       <= {WIDTH{1'b0}};
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div0_q      <= 1'b0;
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      div0_q      <= div0_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// -----------------------------------------------------------------------------
// tb_iter_divider
//   Directed and random checks of iter_divider at WIDTH=32 (DIV0_FAST=1) and
//   WIDTH=8 (DIV0_FAST=0) against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_iter_divider;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // WIDTH=32 instance signals
  logic        iv32, ir32, fl32, ov32, or32, bz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, q32, r32;
  // WIDTH=8 instance signals
  logic        iv8, ir8, fl8, ov8, or8, bz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, q8, r8;

  int n_cmp  = 0;
  int n_fail = 0;

  iter_divider #(.WIDTH(32), .DIV0_FAST(1)) dut32 (
    .clk(clk), .resetn(resetn), .in_valid(iv32), .in_ready(ir32), .div_op(op32),
    .dividend(a32), .divisor(b32), .flush(fl32), .out_valid(ov32), .out_ready(or32),
    .quotient(q32), .remainder(r32), .busy(bz32)
  );

  iter_divider #(.WIDTH(8), .DIV0_FAST(0)) dut8 (
    .clk(clk), .resetn(resetn), .in_valid(iv8), .in_ready(ir8), .div_op(op8),
    .dividend(a8), .divisor(b8), .flush(fl8), .out_valid(ov8), .out_ready(or8),
    .quotient(q8), .remainder(r8), .busy(bz8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero rule.
  task automatic ref_model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                           input logic [1:0] op, output logic [63:0] q, output logic [63:0] r);
    logic [63:0] m, a, b;
    longint sa, sb;
    m = (64'd1 << w) - 64'd1;
    a = a_in & m;
    b = b_in & m;
    if (b == 64'd0) begin
      q = m;
      r = a;
    end else if (op == 2'b10) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'(a << (64 - w)) >>> (64 - w);
      sb = longint'(b << (64 - w)) >>> (64 - w);
      q = 64'(sa / sb) & m;
      r = 64'(sa % sb) & m;
    end
  endtask

  // Present one operation at a negedge and return just after its accept edge.
  task automatic launch(input bit s8, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input string tag);
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(s8 ? ir8 : ir32), 64'd1);
    if (s8) begin
      iv8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      iv32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0];
    end
    @(posedge clk);
    #1;
    iv8  = 1'b0;
    iv32 = 1'b0;
  endtask

  // Count rising edges after the accept edge until out_valid (bounded).
  task automatic wait_done(input bit s8, output int cyc);
    cyc = 0;
    while (!(s8 ? ov8 : ov32) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic release_result(input bit s8, input string tag);
    @(negedge clk);
    if (s8) or8 = 1'b1; else or32 = 1'b1;
    @(posedge clk);
    #1;
    or8  = 1'b0;
    or32 = 1'b0;
    check({tag, ".idle_after"}, 64'(s8 ? {ov8, bz8} : {ov32, bz32}), 64'd0);
  endtask

  task automatic run_op(input bit s8, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input int exp_lat, input string tag);
    logic [63:0] eq, er;
    int cyc;
    ref_model(s8 ? 8 : 32, a, b, op, eq, er);
    launch(s8, a, b, op, tag);
    wait_done(s8, cyc);
    check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, ".quotient"}, 64'(s8 ? {24'd0, q8} : q32), eq);
    check({tag, ".remainder"}, 64'(s8 ? {24'd0, r8} : r32), er);
    release_result(s8, tag);
  endtask

  // Global time limit so the bench cannot hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_q, hold_r, ra, rb;
    logic [1:0]  rop;
    int          cyc;

    iv32 = 1'b0; fl32 = 1'b0; or32 = 1'b0; op32 = 2'b00; a32 = 32'd0; b32 = 32'd0;
    iv8  = 1'b0; fl8  = 1'b0; or8  = 1'b0; op8  = 2'b00; a8  = 8'd0;  b8  = 8'd0;
    resetn = 1'b0;
    #12;
    check("reset.out_valid", 64'(ov32), 64'd0);
    check("reset.busy", 64'(bz32), 64'd0);
    check("reset.quotient", 64'(q32), 64'd0);
    check("reset.remainder", 64'(r32), 64'd0);
    check("reset.in_ready", 64'(ir32), 64'd1);
    @(negedge clk);
    resetn = 1'b1;

    // Illegal op codes are never accepted.
    @(negedge clk);
    iv32 = 1'b1; op32 = 2'b11; a32 = 32'd9; b32 = 32'd3;
    @(posedge clk); #1;
    check("noop11.busy", 64'(bz32), 64'd0);
    @(negedge clk);
    op32 = 2'b00;
    @(posedge clk); #1;
    check("noop00.busy", 64'(bz32), 64'd0);
    iv32 = 1'b0;

    // Directed results and latencies.
    run_op(1'b0, 64'h7,        64'h2,        2'b10, 33, "u7div2");
    run_op(1'b0, 64'hFFFFFFF9, 64'h2,        2'b01, 33, "sm7div2");
    run_op(1'b0, 64'h7,        64'hFFFFFFFE, 2'b01, 33, "s7divm2");
    run_op(1'b0, 64'h80000000, 64'hFFFFFFFF, 2'b01, 33, "s_ovf");
    run_op(1'b0, 64'h12345678, 64'h0,        2'b10, 1,  "u_div0_fast");
    run_op(1'b0, 64'hFFFFFF00, 64'h0,        2'b01, 1,  "s_div0_fast");
    run_op(1'b1, 64'hF9,       64'h0,        2'b01, 9,  "w8_s_div0_full");
    run_op(1'b1, 64'h80,       64'hFF,       2'b01, 9,  "w8_s_ovf");

    // Backpressure: result held, no new accept while DONE.
    launch(1'b0, 64'd1000, 64'd33, 2'b10, "hold");
    wait_done(1'b0, cyc);
    check("hold.latency", 64'(cyc), 64'd33);
    hold_q = q32;
    hold_r = r32;
    check("hold.quotient", 64'(hold_q), 64'd30);
    check("hold.remainder", 64'(hold_r), 64'd10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv32 = 1'b1; op32 = 2'b10; a32 = 32'd5; b32 = 32'd1;
      check("hold.in_ready", 64'(ir32), 64'd0);
      @(posedge clk); #1;
      check("hold.out_valid", 64'(ov32), 64'd1);
      check("hold.q_stable", 64'(q32), 64'(hold_q));
      check("hold.r_stable", 64'(r32), 64'(hold_r));
    end
    iv32 = 1'b0;
    release_result(1'b0, "hold");

    // Flush mid-CALC with a competing in_valid.
    launch(1'b0, 64'hDEAD, 64'h3, 2'b10, "flush");
    repeat (10) @(posedge clk);
    @(negedge clk);
    fl32 = 1'b1; iv32 = 1'b1; op32 = 2'b10; a32 = 32'd50; b32 = 32'd5;
    check("flush.in_ready", 64'(ir32), 64'd0);
    @(posedge clk); #1;
    check("flush.busy", 64'(bz32), 64'd0);
    check("flush.out_valid", 64'(ov32), 64'd0);
    @(negedge clk);
    fl32 = 1'b0; iv32 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov32 || bz32) check("flush.stays_idle", 64'({ov32, bz32}), 64'd0);
    end
    run_op(1'b0, 64'd100, 64'd7, 2'b10, 33, "after_flush");

    // Flush in DONE with out_ready drops the result.
    launch(1'b0, 64'd77, 64'd7, 2'b01, "flush_done");
    wait_done(1'b0, cyc);
    @(negedge clk);
    fl32 = 1'b1; or32 = 1'b1;
    @(posedge clk); #1;
    fl32 = 1'b0; or32 = 1'b0;
    check("flush_done.idle", 64'({ov32, bz32}), 64'd0);

    // Asynchronous reset in the middle of CALC.
    launch(1'b0, 64'd12345, 64'd11, 2'b10, "areset");
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("areset.busy", 64'(bz32), 64'd0);
    check("areset.out_valid", 64'(ov32), 64'd0);
    check("areset.quotient", 64'(q32), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op(1'b0, 64'd12345, 64'd11, 2'b10, 33, "after_reset");

    // Random operands, WIDTH=32.
    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      rop = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      run_op(1'b0, 64'(ra), 64'(rb), rop, (rb == 32'd0) ? 1 : 33, "rnd32");
    end

    // Random operands, WIDTH=8 (full-latency divide-by-zero).
    for (int i = 0; i < 60; i++) begin
      ra  = 32'($urandom_range(0, 255));
      rb  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      rop = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      run_op(1'b1, 64'(ra), 64'(rb), rop, 9, "rnd8");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
